// File: rtl/psg_pkg.sv
// Shared PSG definitions: register-select codes, latch flag position, writer
// FSM states and the field widths the PSG core and its host logic agree on.
package psg_pkg;

    localparam int FREQUENCY_BITS     = 10;
    localparam int ATTENUATION_BITS   = 4;
    localparam int NOISE_CONTROL_BITS = 3;

    localparam int LATCH_FLAG = 7;

    // Register select is {channel, is_attn}, matching bits [6:4] of a latch byte
    localparam logic [2:0] REG_TONE0 = 3'b000;
    localparam logic [2:0] REG_ATTN0 = 3'b001;
    localparam logic [2:0] REG_TONE1 = 3'b010;
    localparam logic [2:0] REG_ATTN1 = 3'b011;
    localparam logic [2:0] REG_TONE2 = 3'b100;
    localparam logic [2:0] REG_ATTN2 = 3'b101;
    localparam logic [2:0] REG_NOISE = 3'b110;
    localparam logic [2:0] REG_ATTN3 = 3'b111;

    typedef enum logic [1:0] {
        STATE_IDLE,
        STATE_LATCH,
        STATE_DATA
    } writer_state_t;

endpackage

// File: rtl/psg_byte_formatter.sv
// Maps one register write (channel, kind, value) onto the PSG latch, data and
// idle-hold bytes. Purely combinational so verification models can reuse it.
module psg_byte_formatter
    import psg_pkg::*;
#(
    parameter int FREQUENCY_BITS     = psg_pkg::FREQUENCY_BITS,
    parameter int ATTENUATION_BITS   = psg_pkg::ATTENUATION_BITS,
    parameter int NOISE_CONTROL_BITS = psg_pkg::NOISE_CONTROL_BITS
) (
    input  logic [1:0]                channel,
    input  logic                      is_attn,
    input  logic [FREQUENCY_BITS-1:0] value,
    output logic [7:0]                latch_byte,
    output logic [7:0]                data_byte,
    output logic [7:0]                hold_byte,
    output logic                      needs_data
);

    logic [2:0] reg_sel;

    always_comb begin
        reg_sel = {channel, is_attn};

        latch_byte             = '0;
        latch_byte[LATCH_FLAG] = 1'b1;
        latch_byte[6:4]        = reg_sel;
        latch_byte[3:0]        = value[ATTENUATION_BITS-1:0];
        if (reg_sel == REG_NOISE) begin
            latch_byte[3:0] = {1'b0, value[NOISE_CONTROL_BITS-1:0]};
        end

        data_byte  = {2'b00, value[FREQUENCY_BITS-1:ATTENUATION_BITS]};
        needs_data = !is_attn && (reg_sel != REG_NOISE);

        // Idle byte must be harmless: re-write the same bits, or nothing at all
        // for noise so the LFSR is not reset again.
        if (needs_data) begin
            hold_byte = data_byte;
        end else if (is_attn) begin
            hold_byte = {4'b0000, value[ATTENUATION_BITS-1:0]};
        end else begin
            hold_byte = 8'h00;
        end
    end

endmodule

// File: rtl/psg_register_writer.sv
// Serialises one host command at a time into PSG latch/data bytes, holding each
// byte for BYTE_GAP cycles and parking a harmless hold byte on the bus between commands.
module psg_register_writer
    import psg_pkg::*;
#(
    parameter int FREQUENCY_BITS     = psg_pkg::FREQUENCY_BITS,
    parameter int ATTENUATION_BITS   = psg_pkg::ATTENUATION_BITS,
    parameter int NOISE_CONTROL_BITS = psg_pkg::NOISE_CONTROL_BITS,
    parameter int BYTE_GAP           = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [1:0]                cmd_channel,
    input  logic                      cmd_is_attn,
    input  logic [FREQUENCY_BITS-1:0] cmd_value,
    output logic [7:0]                bus_data,
    output logic                      bus_strobe,
    output logic                      busy
);

    localparam logic [7:0] GAP_RELOAD = 8'(BYTE_GAP - 1);

    writer_state_t state, next_state;

    logic [7:0]                gap_count;
    logic [1:0]                cap_channel;
    logic                      cap_is_attn;
    logic [FREQUENCY_BITS-1:0] cap_value;

    logic [1:0]                fmt_channel;
    logic                      fmt_is_attn;
    logic [FREQUENCY_BITS-1:0] fmt_value;
    logic [7:0]                fmt_latch, fmt_data, fmt_hold;
    logic                      fmt_needs_data;
    logic                      accept;

    // In IDLE the formatter looks at the live command so the latch byte can be
    // registered on the accepting edge; afterwards it sees the captured copy.
    assign fmt_channel = (state == STATE_IDLE) ? cmd_channel : cap_channel;
    assign fmt_is_attn = (state == STATE_IDLE) ? cmd_is_attn : cap_is_attn;
    assign fmt_value   = (state == STATE_IDLE) ? cmd_value   : cap_value;

    psg_byte_formatter #(
        .FREQUENCY_BITS     (FREQUENCY_BITS),
        .ATTENUATION_BITS   (ATTENUATION_BITS),
        .NOISE_CONTROL_BITS (NOISE_CONTROL_BITS)
    ) u_formatter (
        .channel    (fmt_channel),
        .is_attn    (fmt_is_attn),
        .value      (fmt_value),
        .latch_byte (fmt_latch),
        .data_byte  (fmt_data),
        .hold_byte  (fmt_hold),
        .needs_data (fmt_needs_data)
    );

    assign cmd_ready = (state == STATE_IDLE);
    assign busy      = !cmd_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= STATE_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        case (state)
            STATE_IDLE: begin
                if (cmd_valid) begin
                    accept     = 1'b1;
                    next_state = STATE_LATCH;
                end
            end
            STATE_LATCH: begin
                if (gap_count == 8'd0) begin
                    next_state = fmt_needs_data ? STATE_DATA : STATE_IDLE;
                end
            end
            STATE_DATA: begin
                if (gap_count == 8'd0) begin
                    next_state = STATE_IDLE;
                end
            end
            default: next_state = STATE_IDLE;
        endcase
    end

    // The bus register only changes when a byte boundary is crossed, so in IDLE
    // it simply keeps the hold byte written when the command finished.
    always_ff @(posedge clk) begin
        if (reset) begin
            gap_count   <= '0;
            cap_channel <= '0;
            cap_is_attn <= 1'b0;
            cap_value   <= '0;
            bus_data    <= 8'h00;
            bus_strobe  <= 1'b0;
        end else begin
            bus_strobe <= 1'b0;
            case (state)
                STATE_IDLE: begin
                    if (accept) begin
                        cap_channel <= cmd_channel;
                        cap_is_attn <= cmd_is_attn;
                        cap_value   <= cmd_value;
                        bus_data    <= fmt_latch;
                        bus_strobe  <= 1'b1;
                        gap_count   <= GAP_RELOAD;
                    end
                end
                STATE_LATCH: begin
                    if (gap_count == 8'd0) begin
                        if (fmt_needs_data) begin
                            bus_data   <= fmt_data;
                            bus_strobe <= 1'b1;
                            gap_count  <= GAP_RELOAD;
                        end else begin
                            bus_data <= fmt_hold;
                        end
                    end else begin
                        gap_count <= gap_count - 8'd1;
                    end
                end
                STATE_DATA: begin
                    if (gap_count == 8'd0) begin
                        bus_data <= fmt_hold;
                    end else begin
                        gap_count <= gap_count - 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_psg_register_writer.sv
// Bench for psg_register_writer: one instance with BYTE_GAP=1 and one with BYTE_GAP=4,
// driven by directed and random commands and compared against a byte-sequence model.
module tb_psg_register_writer;

    logic       clk = 1'b0;
    logic       reset       [2];
    logic       cmd_valid   [2];
    logic [1:0] cmd_channel [2];
    logic       cmd_is_attn [2];
    logic [9:0] cmd_value   [2];
    logic       cmd_ready   [2];
    logic [7:0] bus_data    [2];
    logic       bus_strobe  [2];
    logic       busy        [2];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    psg_register_writer #(.BYTE_GAP(1)) u_gap1 (
        .clk         (clk),
        .reset       (reset[0]),
        .cmd_valid   (cmd_valid[0]),
        .cmd_ready   (cmd_ready[0]),
        .cmd_channel (cmd_channel[0]),
        .cmd_is_attn (cmd_is_attn[0]),
        .cmd_value   (cmd_value[0]),
        .bus_data    (bus_data[0]),
        .bus_strobe  (bus_strobe[0]),
        .busy        (busy[0])
    );

    psg_register_writer #(.BYTE_GAP(4)) u_gap4 (
        .clk         (clk),
        .reset       (reset[1]),
        .cmd_valid   (cmd_valid[1]),
        .cmd_ready   (cmd_ready[1]),
        .cmd_channel (cmd_channel[1]),
        .cmd_is_attn (cmd_is_attn[1]),
        .cmd_value   (cmd_value[1]),
        .bus_data    (bus_data[1]),
        .bus_strobe  (bus_strobe[1]),
        .busy        (busy[1])
    );

    function automatic int gap_of(input int u);
        return (u == 0) ? 1 : 4;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end else begin
            n_pass++;
        end
    endtask

    // Reference: the bytes a command puts on the bus, and what stays there afterwards
    task automatic modelCommand(input int ch, input int attn, input int val,
                                output int bytes[$], output int hold);
        int low4, low3, high6;
        low4  = val % 16;
        low3  = val % 8;
        high6 = (val / 16) % 64;
        bytes = {};
        if (ch == 3 && attn == 0) begin
            bytes.push_back(128 + 64 + 32 + low3);
            hold = 0;
        end else if (attn == 1) begin
            bytes.push_back(128 + ch * 32 + 16 + low4);
            hold = low4;
        end else begin
            bytes.push_back(128 + ch * 32 + low4);
            bytes.push_back(high6);
            hold = high6;
        end
    endtask

    task automatic checkIdle(input int u, input int hold, input string tag);
        checkOutput($sformatf("%s_u%0d_bus", tag, u), 32'(bus_data[u]), 32'(hold));
        checkOutput($sformatf("%s_u%0d_strobe", tag, u), 32'(bus_strobe[u]), 32'd0);
        checkOutput($sformatf("%s_u%0d_ready", tag, u), 32'(cmd_ready[u]), 32'd1);
        checkOutput($sformatf("%s_u%0d_busy", tag, u), 32'(busy[u]), 32'd0);
    endtask

    // Called at a negedge where the unit is idle; returns at the negedge where it is ready again
    task automatic applyStimulus(input int u, input int ch, input int attn, input int val,
                                 input bit keep_valid, input int nch, input int nattn,
                                 input int nval, output int hold);
        int bytes[$];
        int g;
        g = gap_of(u);
        modelCommand(ch, attn, val, bytes, hold);
        cmd_valid[u]   = 1'b1;
        cmd_channel[u] = 2'(ch);
        cmd_is_attn[u] = 1'(attn);
        cmd_value[u]   = 10'(val);
        for (int k = 1; k <= g * bytes.size(); k++) begin
            @(negedge clk);
            if (k == 1) begin
                if (keep_valid) begin
                    cmd_channel[u] = 2'(nch);
                    cmd_is_attn[u] = 1'(nattn);
                    cmd_value[u]   = 10'(nval);
                end else begin
                    cmd_valid[u]   = 1'b0;
                    cmd_channel[u] = 2'($urandom);
                    cmd_is_attn[u] = 1'($urandom);
                    cmd_value[u]   = 10'($urandom);
                end
            end
            checkOutput($sformatf("u%0d_k%0d_bus", u, k), 32'(bus_data[u]), 32'(bytes[(k - 1) / g]));
            checkOutput($sformatf("u%0d_k%0d_strobe", u, k), 32'(bus_strobe[u]), 32'(((k - 1) % g) == 0));
            checkOutput($sformatf("u%0d_k%0d_ready", u, k), 32'(cmd_ready[u]), 32'd0);
            checkOutput($sformatf("u%0d_k%0d_busy", u, k), 32'(busy[u]), 32'd1);
        end
        @(negedge clk);
        checkIdle(u, hold, "done");
    endtask

    task automatic idleCycles(input int u, input int n, input int hold);
        cmd_valid[u] = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checkIdle(u, hold, "idle");
        end
    endtask

    initial begin
        int hold, g;
        int ch, attn, val, nch, nattn, nval;
        bit keep;
        int bytes[$];

        for (int u = 0; u < 2; u++) begin
            reset[u] = 1'b1;
            cmd_valid[u] = 1'b0;
            cmd_channel[u] = '0;
            cmd_is_attn[u] = 1'b0;
            cmd_value[u] = '0;
        end
        repeat (2) @(negedge clk);
        for (int u = 0; u < 2; u++) checkIdle(u, 0, "reset");
        reset[0] = 1'b0;
        reset[1] = 1'b0;
        @(negedge clk);

        // Directed writes on the single-cycle-gap writer
        applyStimulus(0, 1, 0, 'h2A5, 1'b0, 0, 0, 0, hold);
        checkOutput("tone_hold_const", 32'(bus_data[0]), 32'h2A);
        idleCycles(0, 2, hold);
        applyStimulus(0, 2, 1, 'h3F7, 1'b0, 0, 0, 0, hold);
        checkOutput("attn_hold_const", 32'(bus_data[0]), 32'h07);
        idleCycles(0, 3, hold);
        applyStimulus(0, 3, 0, 'h005, 1'b0, 0, 0, 0, hold);
        idleCycles(0, 3, hold);

        // Back-pressure on the four-cycle-gap writer: valid stays high while busy
        applyStimulus(1, 0, 0, 'h1C3, 1'b1, 1, 1, 'h00A, hold);
        applyStimulus(1, 1, 1, 'h00A, 1'b0, 0, 0, 0, hold);
        idleCycles(1, 2, hold);

        // Reset arriving while the data byte is on the bus
        g = gap_of(1);
        modelCommand(2, 0, 'h3B9, bytes, hold);
        cmd_valid[1] = 1'b1;
        cmd_channel[1] = 2'd2;
        cmd_is_attn[1] = 1'b0;
        cmd_value[1] = 10'h3B9;
        @(negedge clk);
        cmd_valid[1] = 1'b0;
        repeat (g) @(negedge clk);
        checkOutput("mid_data_bus", 32'(bus_data[1]), 32'(bytes[1]));
        reset[1] = 1'b1;
        @(negedge clk);
        checkIdle(1, 0, "mid_reset");
        reset[1] = 1'b0;
        idleCycles(1, 1, 0);
        applyStimulus(1, 3, 0, 'h3FE, 1'b0, 0, 0, 0, hold);

        // Random command streams, with and without back-pressure and idle gaps
        for (int u = 0; u < 2; u++) begin
            ch = $urandom_range(0, 3);
            attn = $urandom_range(0, 1);
            val = $urandom_range(0, 1023);
            for (int n = 0; n < 30; n++) begin
                nch = $urandom_range(0, 3);
                nattn = $urandom_range(0, 1);
                nval = $urandom_range(0, 1023);
                keep = 1'($urandom_range(0, 1));
                applyStimulus(u, ch, attn, val, keep, nch, nattn, nval, hold);
                if (!keep && $urandom_range(0, 2) == 0) begin
                    idleCycles(u, $urandom_range(1, 3), hold);
                end
                ch = nch;
                attn = nattn;
                val = nval;
            end
            idleCycles(u, 1, hold);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/psg_register_writer.md
# psg_register_writer

Host-side command encoder that drives the 8-bit register-write bus of the PSG core. Accepts one high-level command at a time (channel, register kind, value) over a valid/ready handshake and serialises it into the PSG latch/data byte protocol. Every byte is held for a programmable number of cycles. Between commands the bus carries a harmless "hold" byte, because the PSG samples the bus on every clock. Sits between the host/sequencer logic and the PSG's `ui_in` data input.

## Interface
- `FREQUENCY_BITS`, default 10: tone period width.
- `ATTENUATION_BITS`, default 4: volume field width.
- `NOISE_CONTROL_BITS`, default 3: noise control width.
- `BYTE_GAP`, default 1: cycles each emitted byte is held; legal range 1..255.
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: writer can accept a command; high only in IDLE.
- `cmd_channel` in 2: target channel, 0..2 tone, 3 noise.
- `cmd_is_attn` in 1: 1 = attenuation register, 0 = tone period or noise control.
- `cmd_value` in 10: payload.
  - Tone uses [9:0].
  - Attenuation uses [3:0].
  - Noise uses [2:0].
  - Unused bits are ignored.
- `bus_data` out 8: byte to PSG data input.
- `bus_strobe` out 1: high on the first cycle each new latch/data byte is presented.
- `busy` out 1: inverse of `cmd_ready`.

## Operation
- The command is accepted on a rising edge with `cmd_valid & cmd_ready`. Channel, kind and value are captured in internal registers; the inputs may change afterwards.
- Latch byte:
  - Normal case: {1, ch[1:0], is_attn, v[3:0]}.
  - Noise control (ch=3, is_attn=0): {1,1,1,0,0, v[2:0]}.
- Data byte: {0,0, v[9:4]}. Emitted only for tone period writes (ch 0..2, is_attn=0).
- Hold byte, driven in IDLE:
  - After a tone write: the data byte just sent. The PSG re-writes identical high bits.
  - After an attenuation write: {0000, v[3:0]}. The PSG re-writes the same attenuation.
  - After a noise write: 0x00. The PSG ignores data bytes while its noise register is latched, so the LFSR is not re-reset.
  - After reset: 0x00.
- The latch byte is never held past its gap. Holding a noise latch byte would reset the PSG's noise LFSR on every cycle.
- FSM states: IDLE, LATCH, DATA.
  - IDLE → LATCH on accept. The gap counter loads BYTE_GAP-1.
  - LATCH: drives the latch byte. At counter==0, goes to DATA for tone writes, otherwise to IDLE.
  - DATA: drives the data byte. At counter==0, goes to IDLE.
  - The gap counter decrements once per cycle in LATCH/DATA and reloads on every state entry.
- `cmd_ready` is combinational from the state: high iff state==IDLE. There is no accept in the same cycle the last byte finishes.

## Timing
- Reset values: state IDLE, `bus_data` 0x00, `bus_strobe` 0, `cmd_ready` 1, `busy` 0, hold byte 0x00.
- All outputs are registered except `cmd_ready` and `busy`, which decode the state register.
- With accept at edge N:
  - Latch byte is driven in cycles N+1 .. N+BYTE_GAP.
  - Data byte, when present, is driven in cycles N+BYTE_GAP+1 .. N+2·BYTE_GAP.
  - After that the hold byte is driven and `cmd_ready` returns to 1.
- `bus_strobe` is 1 exactly in cycle N+1 and, for tone writes, in cycle N+BYTE_GAP+1.
- Command period: tone 2·BYTE_GAP+1 cycles, attenuation/noise BYTE_GAP+1 cycles. With BYTE_GAP=1 that is 3 and 2 cycles.
- `cmd_valid` while busy is ignored. The host must hold it until `cmd_ready` is high.
- Reset mid-command: the in-flight command is dropped, and the next cycle shows the reset values. There is no partial completion.
- BYTE_GAP=1: counter==0 is true on state entry, so each byte lasts exactly one cycle.

## Structure
- Shared package `psg_pkg`:
  - Register-select codes: TONE0=3'b000, ATTN0=3'b001, …, NOISE=3'b110, ATTN3=3'b111.
  - LATCH_FLAG bit position.
  - State enum.
  - The width parameters above, which the PSG core shares.
- Sub-module `psg_byte_formatter`: combinational. Maps (channel, is_attn, value) to latch byte, data byte, hold byte and `needs_data`. It is reused by verification models.
- Top level: FSM, gap counter, capture registers, output registers.

## Test plan
- **Tone write, BYTE_GAP=1.** Input: ch=1, tone, value 0x2A5. Expected: `bus_data` 0xA5 with strobe, then 0x2A with strobe; hold 0x2A; `cmd_ready` back after 3 cycles.
- **Attenuation write.** Input: ch=2, attn, value 0x3F7. Expected: latch 0xD7 for one cycle, then hold 0x07 indefinitely; no data byte.
- **Noise write.** Input: ch=3, tone, value 0x005. Expected: latch 0xE5 for exactly one cycle, then 0x00. With the PSG model attached, `reset_noise` pulses exactly once.
- **BYTE_GAP=4 tone write, plus back-pressure.** Input: tone write, with `cmd_valid` held high while busy. Expected: each byte stable 4 cycles; strobe 1 cycle per byte; the second command is accepted on the first ready cycle (cycle 9).
- **Reset mid-DATA.** Expected: the next cycle shows `bus_data` 0x00, `cmd_ready`=1, strobe=0; a following command encodes correctly.
- **End-to-end scoreboard.** Input: random command stream into `psg_register_writer` driving the PSG core. Expected: PSG register file equals the writer's command-derived shadow after each command completes.
